// File: rtl/sm_motor_pkg.sv
// Shared types and constants for the motor control path: FSM states, duty
// word width, default duty clamp, and saturating duty-step helpers.
package sm_motor_pkg;

    localparam int DUTY_W           = 8;
    localparam int MAX_DUTY_DEFAULT = 100;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [1:0] {
        HOLD,
        RAMP,
        BRAKE,
        DEAD
    } motor_state_e;

    function automatic duty_t clamp_duty(input duty_t req, input duty_t max_d);
        return (req > max_d) ? max_d : req;
    endfunction

    // One step from cur toward tgt, landing exactly on tgt instead of overshooting.
    function automatic duty_t step_toward(input duty_t cur, input duty_t tgt, input duty_t step);
        logic [DUTY_W:0] up;
        logic [DUTY_W:0] down_lim;
        up       = {1'b0, cur} + {1'b0, step};
        down_lim = {1'b0, tgt} + {1'b0, step};
        if (cur < tgt) begin
            return (up >= {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
        end
        return ({1'b0, cur} <= down_lim) ? tgt : cur - step;
    endfunction

    function automatic duty_t step_down(input duty_t cur, input duty_t step);
        return ({1'b0, cur} <= {1'b0, step}) ? '0 : cur - step;
    endfunction

endpackage

// File: rtl/sm_tick_divider.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the last count as a
// one-cycle ramp tick.
module sm_tick_divider #(
    parameter int TICK_DIV = 5000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/sm_duty_ramp.sv
// Duty-cycle slew limiter with brake + dead time before direction reversal.
// Optional SM_DUTY_RAMP_ESTOP_LATCH_EN: estop latches until a zero-duty command.
module sm_duty_ramp
    import sm_motor_pkg::*;
#(
    parameter int MAX_DUTY   = MAX_DUTY_DEFAULT,
    parameter int STEP       = 1,
    parameter int TICK_DIV   = 5000,
    parameter int DEAD_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              cmd_dir,
    input  logic              estop,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              dir_out,
    output logic              at_target
);

    localparam duty_t             MAX_D     = duty_t'(MAX_DUTY);
    localparam duty_t             STEP_D    = duty_t'(STEP);
    localparam int                DEAD_W    = $clog2(DEAD_TICKS + 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_TICKS);
    localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

    motor_state_e      state;
    motor_state_e      hs_state;
    duty_t             target;
    duty_t             cmd_target;
    duty_t             ramp_next;
    duty_t             brake_next;
    logic              tgt_dir;
    logic [DEAD_W-1:0] dead_cnt;
    logic              tick;
    logic              handshake;
    logic              latch_ok;

    sm_tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

`ifdef SM_DUTY_RAMP_ESTOP_LATCH_EN
    logic estop_latch;

    // Once tripped, only an explicit zero-duty command re-arms the drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            estop_latch <= 1'b0;
        end else if (estop) begin
            estop_latch <= 1'b1;
        end else if (handshake && cmd_duty == '0) begin
            estop_latch <= 1'b0;
        end
    end

    assign latch_ok = !estop_latch || (cmd_duty == '0);
`else
    assign latch_ok = 1'b1;
`endif

    assign cmd_ready = (state == HOLD || state == RAMP) && !estop && !reset && latch_ok;
    assign handshake = cmd_valid && cmd_ready;

    assign cmd_target = clamp_duty(cmd_duty, MAX_D);
    assign ramp_next  = step_toward(duty_cycle, target, STEP_D);
    assign brake_next = step_down(duty_cycle, STEP_D);

    always_comb begin
        // NOTE: default first so no path through this block leaves hs_state unassigned (no latch).
        hs_state = HOLD;
        if (cmd_dir != dir_out) begin
            hs_state = (duty_cycle != '0) ? BRAKE : DEAD;
        end else if (cmd_target != duty_cycle) begin
            hs_state = RAMP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HOLD;
            duty_cycle <= '0;
            dir_out    <= 1'b0;
            at_target  <= 1'b1;
            target     <= '0;
            tgt_dir    <= 1'b0;
            dead_cnt   <= '0;
        end else if (estop) begin
            state      <= HOLD;
            duty_cycle <= '0;
            target     <= '0;
            at_target  <= 1'b1;
            dead_cnt   <= '0;
        end else if (handshake) begin
            target    <= cmd_target;
            tgt_dir   <= cmd_dir;
            state     <= hs_state;
            at_target <= (hs_state == HOLD);
            if (hs_state == DEAD) begin
                dead_cnt <= DEAD_LOAD;
            end
        end else if (tick) begin
            unique case (state)
                RAMP: begin
                    duty_cycle <= ramp_next;
                    if (ramp_next == target) begin
                        state     <= HOLD;
                        at_target <= 1'b1;
                    end
                end
                BRAKE: begin
                    duty_cycle <= brake_next;
                    if (brake_next == '0) begin
                        state    <= DEAD;
                        dead_cnt <= DEAD_LOAD;
                    end
                end
                DEAD: begin
                    // Direction flips only once the bridge has idled at zero duty.
                    dead_cnt <= dead_cnt - DEAD_ONE;
                    if (dead_cnt == DEAD_ONE) begin
                        dir_out <= tgt_dir;
                        if (target != '0) begin
                            state <= RAMP;
                        end else begin
                            state     <= HOLD;
                            at_target <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_duty_ramp.sv
// Self-checking bench for sm_duty_ramp: vector table, corner-case sequences and
// randomized traffic compared cycle by cycle against an arithmetic reference model.
module tb_sm_duty_ramp;

    localparam int TB_TICK_DIV = 4;
    localparam int TB_STEP     = 1;
    localparam int TB_DEAD     = 2;
    localparam int TB_MAX      = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_duty;
    logic       cmd_dir;
    logic       estop;
    logic [7:0] duty_cycle;
    logic       dir_out;
    logic       at_target;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    sm_duty_ramp #(
        .MAX_DUTY  (TB_MAX),
        .STEP      (TB_STEP),
        .TICK_DIV  (TB_TICK_DIV),
        .DEAD_TICKS(TB_DEAD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_duty  (cmd_duty),
        .cmd_dir   (cmd_dir),
        .estop     (estop),
        .duty_cycle(duty_cycle),
        .dir_out   (dir_out),
        .at_target (at_target)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: motor phase plus plain integer duty/target bookkeeping.
    localparam int PH_HOLD = 0, PH_RAMP = 1, PH_BRAKE = 2, PH_DEAD = 3;
    int m_cnt, m_duty, m_target, m_dir, m_tgt_dir, m_dead, m_phase, m_at, m_latch;

    function automatic bit m_ready();
        return (m_phase == PH_HOLD || m_phase == PH_RAMP) && !estop && !reset
               && (m_latch == 0 || cmd_duty == 8'd0);
    endfunction

    always @(posedge clk) begin
        bit tick;
        bit hs;
        tick = (m_cnt == TB_TICK_DIV - 1);
        hs   = cmd_valid && m_ready();
        if (reset) begin
            m_cnt = 0; m_duty = 0; m_target = 0; m_dir = 0; m_tgt_dir = 0;
            m_dead = 0; m_phase = PH_HOLD; m_at = 1; m_latch = 0;
        end else begin
            m_cnt = tick ? 0 : m_cnt + 1;
            if (estop) begin
                m_duty = 0; m_target = 0; m_phase = PH_HOLD; m_at = 1; m_dead = 0;
`ifdef SM_DUTY_RAMP_ESTOP_LATCH_EN
                m_latch = 1;
`endif
            end else if (hs) begin
                m_target  = (cmd_duty > TB_MAX) ? TB_MAX : int'(cmd_duty);
                m_tgt_dir = int'(cmd_dir);
                if (cmd_duty == 8'd0) m_latch = 0;
                if (int'(cmd_dir) != m_dir) begin
                    m_phase = (m_duty != 0) ? PH_BRAKE : PH_DEAD;
                    if (m_phase == PH_DEAD) m_dead = TB_DEAD;
                end else begin
                    m_phase = (m_target != m_duty) ? PH_RAMP : PH_HOLD;
                end
                m_at = (m_phase == PH_HOLD);
            end else if (tick) begin
                if (m_phase == PH_RAMP) begin
                    if (m_duty < m_target) m_duty = (m_duty + TB_STEP > m_target) ? m_target : m_duty + TB_STEP;
                    else                   m_duty = (m_duty - TB_STEP < m_target) ? m_target : m_duty - TB_STEP;
                    if (m_duty == m_target) begin m_phase = PH_HOLD; m_at = 1; end
                end else if (m_phase == PH_BRAKE) begin
                    m_duty = (m_duty - TB_STEP < 0) ? 0 : m_duty - TB_STEP;
                    if (m_duty == 0) begin m_phase = PH_DEAD; m_dead = TB_DEAD; end
                end else if (m_phase == PH_DEAD) begin
                    m_dead = m_dead - 1;
                    if (m_dead == 0) begin
                        m_dir   = m_tgt_dir;
                        m_phase = (m_target != 0) ? PH_RAMP : PH_HOLD;
                        m_at    = (m_target == 0);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_duty", duty_cycle, m_duty);
            check("model_dir", dir_out, m_dir);
            check("model_at_target", at_target, m_at);
            check("model_cmd_ready", cmd_ready, m_ready());
        end
    end

    task automatic send_cmd(input logic [7:0] d, input logic dir);
        bit done = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_duty  = d;
        cmd_dir   = dir;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        check("handshake_done", done, 1);
    endtask

    task automatic wait_settle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (at_target) break;
        end
        check("settle_at_target", at_target, 1);
    endtask

    task automatic wait_duty(input logic [7:0] d);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (duty_cycle == d) break;
        end
        check("reach_duty", duty_cycle, d);
    endtask

    typedef struct {
        logic [7:0] duty;
        logic       dir;
        logic [7:0] exp_duty;
        logic       exp_dir;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        int peak, low, ready_bad, zero_cnt, est_left, r;
        bit flipped;

        vecs[0] = '{8'd40,  1'b0, 8'd40,  1'b0};
        vecs[1] = '{8'd10,  1'b0, 8'd10,  1'b0};
        vecs[2] = '{8'd30,  1'b1, 8'd30,  1'b1};
        vecs[3] = '{8'd200, 1'b1, 8'd100, 1'b1};
        vecs[4] = '{8'd0,   1'b1, 8'd0,   1'b1};
        vecs[5] = '{8'd0,   1'b0, 8'd0,   1'b0};
        vecs[6] = '{8'd255, 1'b0, 8'd100, 1'b0};
        vecs[7] = '{8'd100, 1'b0, 8'd100, 1'b0};
        vecs[8] = '{8'd101, 1'b1, 8'd100, 1'b1};
        vecs[9] = '{8'd5,   1'b0, 8'd5,   1'b0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_duty = '0; cmd_dir = 1'b0; estop = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_duty", duty_cycle, 0);
        check("reset_dir", dir_out, 0);
        check("reset_at_target", at_target, 1);
        check("reset_ready", cmd_ready, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        for (int i = 0; i < NV; i++) begin
            send_cmd(vecs[i].duty, vecs[i].dir);
            wait_settle();
            check($sformatf("vec%0d_duty", i), duty_cycle, vecs[i].exp_duty);
            check($sformatf("vec%0d_dir", i), dir_out, vecs[i].exp_dir);
        end

        // Mid-ramp retarget: turn at 60, fall to 20 with no overshoot.
        send_cmd(8'd40, 1'b0);
        wait_settle();
        send_cmd(8'd90, 1'b0);
        wait_duty(8'd60);
        send_cmd(8'd20, 1'b0);
        peak = 0; low = 255;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (int'(duty_cycle) > peak) peak = int'(duty_cycle);
            if (int'(duty_cycle) < low) low = int'(duty_cycle);
            if (at_target) break;
        end
        check("retarget_peak", peak, 60);
        check("retarget_low", low, 20);
        check("retarget_final", duty_cycle, 20);

        // Reversal: brake to zero, two dead ticks, then flip and ramp.
        send_cmd(8'd10, 1'b0);
        wait_settle();
        send_cmd(8'd30, 1'b1);
        ready_bad = 0; zero_cnt = 0; flipped = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (dir_out) begin flipped = 1'b1; break; end
            if (cmd_ready) ready_bad++;
            if (duty_cycle == 8'd0) zero_cnt++;
        end
        check("rev_flipped", flipped, 1);
        check("rev_ready_low", ready_bad, 0);
        check("rev_dead_cycles", zero_cnt, TB_DEAD * TB_TICK_DIV);
        check("rev_duty_at_flip", duty_cycle, 0);
        wait_settle();
        check("rev_final_duty", duty_cycle, 30);

        // Emergency stop mid-ramp at 55.
        send_cmd(8'd90, 1'b1);
        wait_duty(8'd55);
        @(posedge clk); #1;
        estop = 1'b1; cmd_valid = 1'b1; cmd_duty = 8'd50; cmd_dir = 1'b1;
        @(negedge clk);
        check("estop_ready_low", cmd_ready, 0);
        check("estop_duty_before_edge", duty_cycle, 55);
        @(negedge clk);
        check("estop_duty_zero", duty_cycle, 0);
        check("estop_at_target", at_target, 1);
        check("estop_dir_kept", dir_out, 1);
        @(posedge clk); #1 estop = 1'b0;
        @(negedge clk);
`ifdef SM_DUTY_RAMP_ESTOP_LATCH_EN
        check("latch_refuses_50", cmd_ready, 0);
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("latch_duty_zero", duty_cycle, 0);
        send_cmd(8'd0, 1'b1);
        send_cmd(8'd50, 1'b1);
`else
        check("resume_ready", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
`endif
        wait_settle();
        check("post_estop_duty", duty_cycle, 50);

        // Command and estop together: estop wins, target stays 0.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_duty = 8'd70; cmd_dir = 1'b1; estop = 1'b1;
        @(negedge clk);
        check("sim_ready_low", cmd_ready, 0);
        @(posedge clk); #1 estop = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("sim_duty_zero", duty_cycle, 0);
        repeat (20) @(negedge clk);
        check("sim_target_zero", duty_cycle, 0);
        check("sim_at_target", at_target, 1);

        // Randomized traffic, checked by the model every cycle.
        est_left = 0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            cmd_valid = ($urandom_range(0, 29) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 3)      cmd_duty = 8'd0;
            else if (r < 4) cmd_duty = 8'($urandom_range(101, 255));
            else            cmd_duty = 8'($urandom_range(0, 100));
            cmd_dir = 1'($urandom_range(0, 1));
            if (est_left > 0) est_left--;
            else if ($urandom_range(0, 499) == 0) est_left = int'($urandom_range(1, 6));
            estop = (est_left > 0);
            reset = ($urandom_range(0, 2999) == 0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; estop = 1'b0; reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
